// File: rtl/ring_slide_endpoint.sv
// ring_slide_endpoint
// Cluster-side endpoint of the inter-cluster slide/reduction ring. It sits
// between the cluster SLDU and its ring router. For every slide command it
// strobes the router configuration and streams the commanded number of beats
// out to the router. It collects the same number of beats back into a small
// receive FIFO and then pulses done.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   cmd_*                     slide command (valid/ready, dir, bypass, beats)
//   tx_*                      outbound beats from the SLDU (valid/ready)
//   rx_*                      inbound beats to the SLDU (valid/ready, FIFO output)
//   ring_*_o / ring_ready_i   beats toward the router
//   ring_*_i / ring_ready_o   beats from the router
//   conf_valid_o/dir/bypass   router configuration strobe and latched settings
//   busy_o, done_o            activity level and completion pulse
module ring_slide_endpoint #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 16,
  parameter int RxDepth   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_dir_i,
  input  logic                 cmd_bypass_i,
  input  logic [CntWidth-1:0]  cmd_beats_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [DataWidth-1:0] ring_data_o,
  output logic                 ring_valid_o,
  input  logic                 ring_ready_i,
  input  logic [DataWidth-1:0] ring_data_i,
  input  logic                 ring_valid_i,
  output logic                 ring_ready_o,
  output logic                 conf_valid_o,
  output logic                 conf_dir_o,
  output logic                 conf_bypass_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int PtrWidth = (RxDepth > 1) ? $clog2(RxDepth) : 1;
  localparam logic [PtrWidth:0]   FifoFull  = (PtrWidth+1)'(RxDepth);
  localparam logic [PtrWidth:0]   FifoZero  = {(PtrWidth+1){1'b0}};
  localparam logic [PtrWidth:0]   FifoOne   = {{PtrWidth{1'b0}}, 1'b1};
  localparam logic [PtrWidth-1:0] PtrOne    = {{(PtrWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] CntZero   = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne    = {{(CntWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONF = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                state_r;
  logic                  dir_r;
  logic                  bypass_r;
  logic [CntWidth-1:0]   beats_r;
  logic [CntWidth-1:0]   tx_cnt_r;
  logic [CntWidth-1:0]   rx_cnt_r;
  logic [DataWidth-1:0]  fifo_mem_r [RxDepth];
  logic [PtrWidth-1:0]   wr_ptr_r;
  logic [PtrWidth-1:0]   rd_ptr_r;
  logic [PtrWidth:0]     fifo_cnt_r;

  logic in_xfer_s;
  logic tx_open_s;
  logic rx_open_s;
  logic fifo_empty_s;
  logic fifo_full_s;
  logic tx_ready_s;
  logic ring_ready_s;
  logic rx_valid_s;
  logic tx_hs_s;
  logic push_s;
  logic pop_s;
  logic xfer_done_s;

  // Handshake qualifiers. The counters stop each side at the commanded length.
  always_comb begin
    in_xfer_s    = (state_r == ST_XFER) && !rst_i;
    tx_open_s    = in_xfer_s && (tx_cnt_r < beats_r);
    rx_open_s    = in_xfer_s && (rx_cnt_r < beats_r);
    fifo_empty_s = (fifo_cnt_r == FifoZero);
    fifo_full_s  = (fifo_cnt_r == FifoFull);
    tx_ready_s   = tx_open_s && ring_ready_i;
    // Full blocks the router even when the SLDU pops this cycle, so there is
    // no combinational path from rx_ready_i to ring_ready_o.
    ring_ready_s = rx_open_s && !fifo_full_s;
    rx_valid_s   = !fifo_empty_s && !rst_i;
    tx_hs_s      = tx_valid_i && tx_ready_s;
    push_s       = ring_valid_i && ring_ready_s;
    pop_s        = rx_valid_s && rx_ready_i;
    xfer_done_s  = (tx_cnt_r == beats_r) && (rx_cnt_r == beats_r) && fifo_empty_s;
  end

  // Output decode; every output is forced low while reset is asserted.
  always_comb begin
    if (rst_i) begin
      cmd_ready_o   = 1'b0;
      tx_ready_o    = 1'b0;
      rx_data_o     = {DataWidth{1'b0}};
      rx_valid_o    = 1'b0;
      ring_data_o   = {DataWidth{1'b0}};
      ring_valid_o  = 1'b0;
      ring_ready_o  = 1'b0;
      conf_valid_o  = 1'b0;
      conf_dir_o    = 1'b0;
      conf_bypass_o = 1'b0;
      busy_o        = 1'b0;
      done_o        = 1'b0;
    end else begin
      cmd_ready_o   = (state_r == ST_IDLE);
      tx_ready_o    = tx_ready_s;
      rx_data_o     = fifo_mem_r[rd_ptr_r];
      rx_valid_o    = rx_valid_s;
      ring_data_o   = tx_data_i;
      ring_valid_o  = tx_valid_i && tx_open_s;
      ring_ready_o  = ring_ready_s;
      conf_valid_o  = (state_r == ST_CONF);
      conf_dir_o    = dir_r;
      conf_bypass_o = bypass_r;
      busy_o        = (state_r != ST_IDLE);
      done_o        = (state_r == ST_DONE);
    end
  end

  // Command FSM with latched command fields and the two beat counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      dir_r    <= 1'b0;
      bypass_r <= 1'b0;
      beats_r  <= CntZero;
      tx_cnt_r <= CntZero;
      rx_cnt_r <= CntZero;
    end else begin
      if (tx_hs_s) begin
        tx_cnt_r <= tx_cnt_r + CntOne;
      end
      if (push_s) begin
        rx_cnt_r <= rx_cnt_r + CntOne;
      end
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            dir_r    <= cmd_dir_i;
            bypass_r <= cmd_bypass_i;
            beats_r  <= cmd_beats_i;
            tx_cnt_r <= CntZero;
            rx_cnt_r <= CntZero;
            state_r  <= ST_CONF;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_CONF: begin
          if (bypass_r || (beats_r == CntZero)) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (xfer_done_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_XFER;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Receive FIFO pointers and occupancy; reset discards in-flight beats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r   <= {PtrWidth{1'b0}};
      rd_ptr_r   <= {PtrWidth{1'b0}};
      fifo_cnt_r <= FifoZero;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrOne;
      end
      if (push_s && !pop_s) begin
        fifo_cnt_r <= fifo_cnt_r + FifoOne;
      end else if (pop_s && !push_s) begin
        fifo_cnt_r <= fifo_cnt_r - FifoOne;
      end else begin
        fifo_cnt_r <= fifo_cnt_r;
      end
    end
  end

  // Receive FIFO storage; contents are only meaningful behind valid pointers.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= ring_data_i;
    end
  end

endmodule

// File: tb/tb_ring_slide_endpoint.sv
module tb_ring_slide_endpoint;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int RD = 2;

  // flag vector order: cmd_ready busy conf_valid conf_dir conf_bypass done
  //                    tx_ready ring_valid ring_ready rx_valid
  localparam logic [9:0] F_CMDRDY = 10'b10_0000_0000;
  localparam logic [9:0] F_BUSY   = 10'b01_0000_0000;
  localparam logic [9:0] F_CONF   = 10'b00_1000_0000;
  localparam logic [9:0] F_DIR    = 10'b00_0100_0000;
  localparam logic [9:0] F_BYP    = 10'b00_0010_0000;
  localparam logic [9:0] F_DONE   = 10'b00_0001_0000;
  localparam logic [9:0] F_TXRDY  = 10'b00_0000_1000;
  localparam logic [9:0] F_RVAL   = 10'b00_0000_0100;
  localparam logic [9:0] F_RRDY   = 10'b00_0000_0010;
  localparam logic [9:0] F_RXV    = 10'b00_0000_0001;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o, cmd_dir_i = 1'b0, cmd_bypass_i = 1'b0;
  logic [CW-1:0] cmd_beats_i = '0;
  logic [DW-1:0] tx_data_i = '0, rx_data_o, ring_data_o, ring_data_i = '0;
  logic tx_valid_i = 1'b0, tx_ready_o, rx_valid_o, rx_ready_i = 1'b0;
  logic ring_valid_o, ring_ready_i = 1'b0, ring_valid_i = 1'b0, ring_ready_o;
  logic conf_valid_o, conf_dir_o, conf_bypass_o, busy_o, done_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ring_slide_endpoint #(.DataWidth(DW), .CntWidth(CW), .RxDepth(RD)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_dir_i(cmd_dir_i),
    .cmd_bypass_i(cmd_bypass_i), .cmd_beats_i(cmd_beats_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .ring_data_o(ring_data_o), .ring_valid_o(ring_valid_o), .ring_ready_i(ring_ready_i),
    .ring_data_i(ring_data_i), .ring_valid_i(ring_valid_i), .ring_ready_o(ring_ready_o),
    .conf_valid_o(conf_valid_o), .conf_dir_o(conf_dir_o), .conf_bypass_o(conf_bypass_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    logic          rst;
    logic          cmd_valid;
    logic          dir;
    logic          bypass;
    logic [CW-1:0] beats;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          rx_ready;
    logic          ring_ready;
    logic          ring_valid;
    logic [DW-1:0] ring_data;
    logic [9:0]    exp_flags;
    logic [DW-1:0] exp_rx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, cv, dir, byp, input logic [CW-1:0] beats,
                             input logic txv, input logic [DW-1:0] txd,
                             input logic rxr, rgr, rgv, input logic [DW-1:0] rgd,
                             input logic [9:0] ef, input logic [DW-1:0] erx);
    vec_t r;
    r.rst = rst; r.cmd_valid = cv; r.dir = dir; r.bypass = byp; r.beats = beats;
    r.tx_valid = txv; r.tx_data = txd; r.rx_ready = rxr; r.ring_ready = rgr;
    r.ring_valid = rgv; r.ring_data = rgd; r.exp_flags = ef; r.exp_rx = erx;
    return r;
  endfunction

  function automatic logic [9:0] flags();
    return {cmd_ready_o, busy_o, conf_valid_o, conf_dir_o, conf_bypass_o, done_o,
            tx_ready_o, ring_valid_o, ring_ready_o, rx_valid_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got[$];
    int pushes, n_done, done_at, last_pop, tx_hs;

    // ---------------- reset + basic transfer, table driven ----------------
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, F_CMDRDY, 0));
    tbl.push_back(v(0, 1, 1, 0, 4, 1, 64'h10, 1, 1, 0, 0, F_CMDRDY, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h10, 1, 1, 0, 0, F_BUSY | F_CONF | F_DIR, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h10, 1, 1, 1, 64'hA0,
                    F_BUSY | F_DIR | F_TXRDY | F_RVAL | F_RRDY, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h11, 1, 1, 1, 64'hA1,
                    F_BUSY | F_DIR | F_TXRDY | F_RVAL | F_RRDY | F_RXV, 64'hA0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h12, 1, 1, 1, 64'hA2,
                    F_BUSY | F_DIR | F_TXRDY | F_RVAL | F_RRDY | F_RXV, 64'hA1));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h13, 1, 1, 1, 64'hA3,
                    F_BUSY | F_DIR | F_TXRDY | F_RVAL | F_RRDY | F_RXV, 64'hA2));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h14, 1, 1, 0, 0, F_BUSY | F_DIR | F_RXV, 64'hA3));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h14, 1, 1, 0, 0, F_BUSY | F_DIR, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h14, 1, 1, 0, 0, F_BUSY | F_DIR | F_DONE, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 64'h14, 1, 1, 0, 0, F_CMDRDY | F_DIR, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      rst_i = tbl[i].rst; cmd_valid_i = tbl[i].cmd_valid; cmd_dir_i = tbl[i].dir;
      cmd_bypass_i = tbl[i].bypass; cmd_beats_i = tbl[i].beats;
      tx_valid_i = tbl[i].tx_valid; tx_data_i = tbl[i].tx_data;
      rx_ready_i = tbl[i].rx_ready; ring_ready_i = tbl[i].ring_ready;
      ring_valid_i = tbl[i].ring_valid; ring_data_i = tbl[i].ring_data;
      #1;
      chk($sformatf("row%0d_flags", i), flags(), tbl[i].exp_flags);
      if ((tbl[i].exp_flags & F_RXV) != 10'd0)
        chk($sformatf("row%0d_rx_data", i), rx_data_o, tbl[i].exp_rx);
      if ((tbl[i].exp_flags & F_RVAL) != 10'd0)
        chk($sformatf("row%0d_ring_data", i), ring_data_o, tbl[i].tx_data);
    end

    // ---------------- receive backpressure, 6 beats ----------------
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_dir_i = 1'b0; cmd_bypass_i = 1'b0; cmd_beats_i = 16'd6;
    tx_valid_i = 1'b1; tx_data_i = 64'h20; ring_ready_i = 1'b1; ring_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    #1 chk("bp_cmd_ready", cmd_ready_o, 1'b1);
    @(negedge clk_i); cmd_valid_i = 1'b0;
    #1 chk("bp_conf_valid", conf_valid_o, 1'b1);
    chk("bp_conf_dir", conf_dir_o, 1'b0);
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      tx_data_i = 64'h20 + i; ring_valid_i = 1'b1; ring_data_i = 64'hB0 + pushes;
      #1;
      chk($sformatf("bp_tx_ready%0d", i), tx_ready_o, 1'b1);
      chk($sformatf("bp_ring_ready%0d", i), ring_ready_o, (i < 2));
      chk($sformatf("bp_rx_valid%0d", i), rx_valid_o, (i >= 1));
      if (ring_valid_i && ring_ready_o) pushes++;
    end
    @(negedge clk_i); tx_data_i = 64'h26;
    #1 chk("bp_extra_tx_ready", tx_ready_o, 1'b0);
    chk("bp_extra_ring_valid", ring_valid_o, 1'b0);
    got.delete(); n_done = 0; done_at = -1; last_pop = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      rx_ready_i = 1'b1; ring_valid_i = (pushes < 6); ring_data_i = 64'hB0 + pushes;
      #1;
      if (c == 0) begin
        chk("bp_full_pop_ring_ready", ring_ready_o, 1'b0);
        chk("bp_first_rx", rx_data_o, 64'hB0);
      end
      if (rx_valid_o && rx_ready_i) begin got.push_back(rx_data_o); last_pop = c; end
      if (ring_valid_i && ring_ready_o) pushes++;
      if (done_o) begin n_done++; done_at = c; end
    end
    chk("bp_rx_count", got.size(), 6);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("bp_rx_order%0d", k), got[k], 64'hB0 + k);
    chk("bp_done_count", n_done, 1);
    chk("bp_done_after_pop", done_at, last_pop + 2);
    ring_valid_i = 1'b0;

    // ---------------- zero-length, then bypass ----------------
    for (int t = 0; t < 2; t++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_dir_i = 1'b1; cmd_bypass_i = (t == 1);
      cmd_beats_i = (t == 1) ? 16'd5 : 16'd0;
      tx_valid_i = 1'b1; ring_valid_i = 1'b1; ring_data_i = 64'hEE;
      ring_ready_i = 1'b1; rx_ready_i = 1'b1;
      #1 chk($sformatf("zb%0d_cmd_ready", t), cmd_ready_o, 1'b1);
      @(negedge clk_i); cmd_valid_i = 1'b0;
      #1 chk($sformatf("zb%0d_conf_valid", t), conf_valid_o, 1'b1);
      chk($sformatf("zb%0d_conf_bypass", t), conf_bypass_o, (t == 1));
      chk($sformatf("zb%0d_c1_hs", t), {tx_ready_o, ring_valid_o, ring_ready_o, done_o}, 4'b0);
      @(negedge clk_i);
      #1 chk($sformatf("zb%0d_done", t), done_o, 1'b1);
      chk($sformatf("zb%0d_c2_hs", t), {tx_ready_o, ring_valid_o, ring_ready_o}, 3'b0);
      @(negedge clk_i);
      #1 chk($sformatf("zb%0d_idle", t), {cmd_ready_o, done_o, rx_valid_o}, 3'b100);
    end
    ring_valid_i = 1'b0;

    // ---------------- reset mid-transfer ----------------
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_dir_i = 1'b1; cmd_bypass_i = 1'b0; cmd_beats_i = 16'd3;
    tx_valid_i = 1'b0; ring_valid_i = 1'b0; rx_ready_i = 1'b0; ring_ready_i = 1'b1;
    #1 chk("rm_cmd_ready", cmd_ready_o, 1'b1);
    @(negedge clk_i); cmd_valid_i = 1'b0;
    #1 chk("rm_conf_valid", conf_valid_o, 1'b1);
    @(negedge clk_i); ring_valid_i = 1'b1; ring_data_i = 64'hC0;
    #1 chk("rm_push_ready", ring_ready_o, 1'b1);
    @(negedge clk_i); ring_valid_i = 1'b0;
    #1 chk("rm_rx_valid", rx_valid_o, 1'b1);
    chk("rm_rx_data", rx_data_o, 64'hC0);
    rst_i = 1'b1;
    #1 chk("rm_outputs_low", flags(), 10'd0);
    chk("rm_rx_data_low", rx_data_o, 64'h0);
    @(negedge clk_i); rst_i = 1'b0;
    #1 chk("rm_after_reset", flags(), F_CMDRDY);

    // follow-up 2-beat command
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_dir_i = 1'b0; cmd_beats_i = 16'd2;
    tx_valid_i = 1'b1; tx_data_i = 64'h30; rx_ready_i = 1'b1; ring_ready_i = 1'b1;
    #1 chk("f2_cmd_ready", cmd_ready_o, 1'b1);
    got.delete(); n_done = 0; done_at = -1; pushes = 0; tx_hs = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      ring_valid_i = (c >= 2) && (pushes < 2); ring_data_i = 64'hD0 + pushes;
      #1;
      if (tx_valid_i && tx_ready_o) tx_hs++;
      if (rx_valid_o && rx_ready_i) got.push_back(rx_data_o);
      if (ring_valid_i && ring_ready_o) pushes++;
      if (done_o) begin n_done++; done_at = c; end
    end
    chk("f2_tx_count", tx_hs, 2);
    chk("f2_rx_count", got.size(), 2);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("f2_rx_order%0d", k), got[k], 64'hD0 + k);
    chk("f2_done_count", n_done, 1);
    chk("f2_done_cycle", done_at, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
